// File: rtl/cash_pkg.sv
// Shared types for the cash cell controller: request opcodes and controller FSM states.
package cash_pkg;

  localparam int CASH_DATA_WIDTH = 32;
  localparam int CASH_NUM_CELLS  = 8;

  typedef enum logic [1:0] {
    READ   = 2'b00,
    WRITE  = 2'b01,
    DELETE = 2'b10,
    SEARCH = 2'b11
  } cash_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    SCAN   = 2'd2,
    RESP   = 2'd3
  } cash_ctrl_state_t;

endpackage

// File: rtl/cash_cell_ctrl_if.sv
// Request/response channel between the hashtable lookup logic and the cell controller.
// Handshake: a beat transfers on a rising edge where valid and ready are both 1; the
// sender holds valid and its payload stable until that edge, ready may depend on state only.
interface cash_cell_ctrl_if
  import cash_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 3
);
  logic                  req_valid;
  logic                  req_ready;
  cash_op_t              req_op;
  logic [IDX_WIDTH-1:0]  req_idx;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_hit;
  logic [IDX_WIDTH-1:0]  rsp_idx;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_op, req_idx, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_idx, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_data
  );
endinterface

// File: rtl/cash_cell_bank.sv
// Bank of NUM_CELLS data cells with shared strobes and a packed read bus.
module cash_cell_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CELLS  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CELLS-1:0]            cell_cs,
  input  logic                            cell_we,
  input  logic                            cell_del,
  input  logic [DATA_WIDTH-1:0]           cell_wdata,
  output logic [NUM_CELLS*DATA_WIDTH-1:0] cell_rdata
);
  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    cash_data_cell #(.DATA_WIDTH(DATA_WIDTH)) u_cell (
      .clk   (clk),
      .reset (reset),
      .cs    (cell_cs[i]),
      .we    (cell_we),
      .del   (cell_del),
      .wdata (cell_wdata),
      .rdata (cell_rdata[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: rtl/cash_data_cell.sv
// One storage word of the cell bank; written or cleared when selected, cleared by reset.
module cash_data_cell #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  del,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (cs && del) begin
      data_q <= '0;
    end else if (cs && we) begin
      data_q <= wdata;
    end
  end

  assign rdata = data_q;
endmodule

// File: rtl/cash_cell_ctrl.sv
// Initiator-side controller for the cash cell bank: one outstanding READ/WRITE/DELETE/SEARCH
// at a time, per-cell valid tracking, and a linear one-cell-per-cycle search scan.
module cash_cell_ctrl
  import cash_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CELLS  = 8,
  parameter int IDX_WIDTH  = $clog2(NUM_CELLS)
) (
  input  logic                            clk,
  input  logic                            reset,
  cash_cell_ctrl_if.slave                 bus,
  output logic [NUM_CELLS-1:0]            cell_cs,
  output logic                            cell_we,
  output logic                            cell_del,
  output logic [DATA_WIDTH-1:0]           cell_wdata,
  input  logic [NUM_CELLS*DATA_WIDTH-1:0] cell_rdata,
  output cash_ctrl_state_t                state_dbg
);
  localparam logic [IDX_WIDTH:0]   NUM_CELLS_W = (IDX_WIDTH+1)'(NUM_CELLS);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(NUM_CELLS - 1);

  cash_ctrl_state_t      state_q, state_d;
  cash_op_t              op_q;
  logic [IDX_WIDTH-1:0]  idx_q, scan_idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [NUM_CELLS-1:0]  valid_q;
  logic                  rsp_hit_q;
  logic [IDX_WIDTH-1:0]  rsp_idx_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [DATA_WIDTH-1:0] cell_word [NUM_CELLS];
  logic                  in_range, scan_hit, req_ready_c, rsp_valid_c;
  logic [NUM_CELLS-1:0]  sel;

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_word
    assign cell_word[i] = cell_rdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign in_range = ({1'b0, idx_q} < NUM_CELLS_W);
  assign sel      = NUM_CELLS'(1) << idx_q;
  assign scan_hit = valid_q[scan_idx_q] && (cell_word[scan_idx_q] == data_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    cell_cs     = '0;
    cell_we     = 1'b0;
    cell_del    = 1'b0;
    cell_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) state_d = (bus.req_op == SEARCH) ? SCAN : ACCESS;
      end
      ACCESS: begin
        if (in_range && op_q == WRITE) begin
          cell_cs    = sel;
          cell_we    = 1'b1;
          cell_wdata = data_q;
        end else if (in_range && op_q == DELETE) begin
          cell_cs  = sel;
          cell_del = 1'b1;
        end
        state_d = RESP;
      end
      SCAN: begin
        if (scan_hit || scan_idx_q == LAST_IDX) state_d = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset is synchronous, so the state register is still stale in the reset cycle.
    if (reset) begin
      req_ready_c = 1'b0;
      rsp_valid_c = 1'b0;
      cell_cs     = '0;
      cell_we     = 1'b0;
      cell_del    = 1'b0;
      cell_wdata  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= READ;
      idx_q      <= '0;
      data_q     <= '0;
      scan_idx_q <= '0;
      valid_q    <= '0;
      rsp_hit_q  <= 1'b0;
      rsp_idx_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_q       <= bus.req_op;
            idx_q      <= bus.req_idx;
            data_q     <= bus.req_data;
            scan_idx_q <= '0;
          end
        end
        ACCESS: begin
          rsp_idx_q <= idx_q;
          if (!in_range) begin
            rsp_hit_q  <= 1'b0;
            rsp_data_q <= '0;
          end else if (op_q == WRITE) begin
            valid_q[idx_q] <= 1'b1;
            rsp_hit_q      <= 1'b1;
            rsp_data_q     <= data_q;
          end else if (op_q == DELETE) begin
            valid_q[idx_q] <= 1'b0;
            rsp_hit_q      <= valid_q[idx_q];
            rsp_data_q     <= '0;
          end else begin
            rsp_hit_q  <= valid_q[idx_q];
            rsp_data_q <= cell_word[idx_q];
          end
        end
        SCAN: begin
          if (scan_hit) begin
            rsp_hit_q  <= 1'b1;
            rsp_idx_q  <= scan_idx_q;
            rsp_data_q <= cell_word[scan_idx_q];
          end else if (scan_idx_q == LAST_IDX) begin
            rsp_hit_q  <= 1'b0;
            rsp_idx_q  <= '0;
            rsp_data_q <= '0;
          end else begin
            scan_idx_q <= scan_idx_q + IDX_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_hit   = rsp_hit_q & ~reset;
  assign bus.rsp_idx   = reset ? '0 : rsp_idx_q;
  assign bus.rsp_data  = reset ? '0 : rsp_data_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_cash_cell_ctrl.sv
// Self-checking bench for cash_cell_ctrl driving a real cash_cell_bank.
module tb_cash_cell_ctrl
  import cash_pkg::*;
;
  localparam int DW = 32;
  localparam int NC = 8;
  localparam int IW = 3;
  localparam int RW = 1 + IW + DW;

  logic clk, reset;
  logic [NC-1:0]    cell_cs;
  logic             cell_we, cell_del;
  logic [DW-1:0]    cell_wdata;
  logic [NC*DW-1:0] cell_rdata;
  cash_ctrl_state_t state_dbg;

  cash_cell_ctrl_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

  cash_cell_ctrl #(.DATA_WIDTH(DW), .NUM_CELLS(NC)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .cell_cs(cell_cs), .cell_we(cell_we), .cell_del(cell_del),
    .cell_wdata(cell_wdata), .cell_rdata(cell_rdata), .state_dbg(state_dbg)
  );

  cash_cell_bank #(.DATA_WIDTH(DW), .NUM_CELLS(NC)) bank (
    .clk(clk), .reset(reset), .cell_cs(cell_cs), .cell_we(cell_we),
    .cell_del(cell_del), .cell_wdata(cell_wdata), .cell_rdata(cell_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [RW-1:0] exp_q[$];
  int            lat_q[$];
  logic          m_valid [NC];
  logic [DW-1:0] m_data  [NC];

  // strobe monitor
  int          strobe_cnt = 0;
  int          cs_violations = 0;
  logic [NC-1:0] last_cs = '0;
  logic        last_we = 1'b0, last_del = 1'b0;
  always @(negedge clk) begin
    if (cell_cs != '0) begin
      strobe_cnt++;
      last_cs  = cell_cs;
      last_we  = cell_we;
      last_del = cell_del;
      if (((cell_cs & (cell_cs - 1'b1)) != '0) || state_dbg != ACCESS) cs_violations++;
    end
  end

  function automatic logic [RW-1:0] predict(input cash_op_t op, input logic [IW-1:0] idx,
                                            input logic [DW-1:0] d, output int lat);
    logic [RW-1:0] r;
    lat = 2;
    case (op)
      WRITE:  begin r = {1'b1, idx, d}; m_valid[idx] = 1'b1; m_data[idx] = d; end
      DELETE: begin r = {m_valid[idx], idx, 32'h0}; m_valid[idx] = 1'b0; m_data[idx] = '0; end
      READ:   r = {m_valid[idx], idx, m_data[idx]};
      default: begin
        r = '0;
        lat = NC + 1;
        for (int i = NC - 1; i >= 0; i--)
          if (m_valid[i] && m_data[i] == d) begin r = {1'b1, 3'(i), d}; lat = i + 2; end
      end
    endcase
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NC; i++) begin m_valid[i] = 1'b0; m_data[i] = '0; end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1; bus.req_valid = 1'b0; bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  // driver: one full request/response transaction, response accepted as soon as it appears
  task automatic send_req(input cash_op_t op, input logic [IW-1:0] idx, input logic [DW-1:0] d,
                          output int lat, output logic [RW-1:0] got, output logic ok, output int acc);
    int el, n;
    exp_q.push_back(predict(op, idx, d, el));
    lat_q.push_back(el);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_idx = idx; bus.req_data = d;
    n = 0;
    while (!bus.req_ready && n < 40) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    ok  = bus.rsp_valid;
    got = {bus.rsp_hit, bus.rsp_idx, bus.rsp_data};
    bus.rsp_ready = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_hit, cell_cs, cell_we, cell_del} !== '0) begin
      failures++; $display("FAIL reset_outputs req_ready=%b rsp_valid=%b cs=%h", bus.req_ready, bus.rsp_valid, cell_cs);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || state_dbg !== IDLE) begin
      failures++; $display("FAIL reset_release req_ready=%b state=%0d exp 1/IDLE", bus.req_ready, state_dbg);
    end
  endtask

  task automatic test_write_read();
    int lat, acc, s0; logic [RW-1:0] got, e; logic ok; int el;
    s0 = strobe_cnt;
    send_req(WRITE, 3'd3, 32'hDEADBEEF, lat, got, ok, acc);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (!ok || got !== e) begin failures++; $display("FAIL wr3_rsp got=%h exp=%h", got, e); end
    checks++; if (lat != el) begin failures++; $display("FAIL wr3_lat got=%0d exp=%0d", lat, el); end
    checks++;
    if (strobe_cnt - s0 != 1 || last_cs !== 8'h08 || last_we !== 1'b1 || last_del !== 1'b0) begin
      failures++; $display("FAIL wr3_strobe cycles=%0d cs=%h we=%b exp 1/08/1", strobe_cnt - s0, last_cs, last_we);
    end
    send_req(READ, 3'd3, 32'h0, lat, got, ok, acc);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (!ok || got !== e) begin failures++; $display("FAIL rd3_rsp got=%h exp=%h", got, e); end
    checks++; if (lat != el) begin failures++; $display("FAIL rd3_lat got=%0d exp=%0d", lat, el); end
  endtask

  task automatic test_search();
    int lat, acc, el; logic [RW-1:0] got, e; logic ok;
    send_req(WRITE, 3'd2, 32'h11, lat, got, ok, acc);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (!ok || got !== e) begin failures++; $display("FAIL wr2_rsp got=%h exp=%h", got, e); end
    send_req(WRITE, 3'd5, 32'h11, lat, got, ok, acc);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (!ok || got !== e) begin failures++; $display("FAIL wr5_rsp got=%h exp=%h", got, e); end
    send_req(SEARCH, 3'd0, 32'h11, lat, got, ok, acc);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (!ok || got !== e) begin failures++; $display("FAIL search_lowest got=%h exp=%h", got, e); end
    checks++; if (lat != 4) begin failures++; $display("FAIL search_lowest_lat got=%0d exp=4", lat); end
  endtask

  task automatic test_delete();
    int lat, acc, el; logic [RW-1:0] got, e; logic ok;
    send_req(DELETE, 3'd2, 32'h0, lat, got, ok, acc);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (!ok || got !== e) begin failures++; $display("FAIL del2_rsp got=%h exp=%h", got, e); end
    send_req(SEARCH, 3'd0, 32'h11, lat, got, ok, acc);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (!ok || got !== e) begin failures++; $display("FAIL search_after_del got=%h exp=%h", got, e); end
    checks++; if (lat != el) begin failures++; $display("FAIL search_after_del_lat got=%0d exp=%0d", lat, el); end
    send_req(DELETE, 3'd2, 32'h0, lat, got, ok, acc);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (!ok || got !== e) begin failures++; $display("FAIL del2_again got=%h exp=%h", got, e); end
  endtask

  task automatic test_backpressure();
    int lat, acc, el, n; logic [RW-1:0] got, e; logic ok; logic [DW-1:0] cap;
    send_req(WRITE, 3'd4, 32'hCAFE0001, lat, got, ok, acc);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (!ok || got !== e) begin failures++; $display("FAIL wr4_rsp got=%h exp=%h", got, e); end
    e = predict(READ, 3'd4, 32'h0, el);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = READ; bus.req_idx = 3'd4; bus.req_data = '0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 40) begin @(negedge clk); n++; end
    cap = bus.rsp_data;
    checks++;
    if ({bus.rsp_hit, bus.rsp_idx, bus.rsp_data} !== e) begin
      failures++; $display("FAIL bp_rsp got=%h exp=%h", {bus.rsp_hit, bus.rsp_idx, bus.rsp_data}, e);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== cap || bus.req_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold cyc%0d valid=%b data=%h req_ready=%b exp 1/%h/0", i, bus.rsp_valid, bus.rsp_data, bus.req_ready, cap);
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL bp_release req_ready=%b rsp_valid=%b exp 1/0", bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_reset_mid_scan();
    int lat, acc, el; logic [RW-1:0] got, e; logic ok;
    send_req(WRITE, 3'd6, 32'h77, lat, got, ok, acc);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (!ok || got !== e) begin failures++; $display("FAIL wr6_rsp got=%h exp=%h", got, e); end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_op = SEARCH; bus.req_idx = '0; bus.req_data = 32'h77;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++; if (state_dbg !== SCAN) begin failures++; $display("FAIL mid_scan_state got=%0d exp=%0d", state_dbg, SCAN); end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_hit, bus.rsp_idx, bus.rsp_data, cell_cs, cell_we, cell_del, cell_wdata} !== '0) begin
      failures++; $display("FAIL mid_scan_reset_outputs req_ready=%b rsp_valid=%b cs=%h", bus.req_ready, bus.rsp_valid, cell_cs);
    end
    @(negedge clk);
    checks++;
    if (state_dbg !== IDLE || {bus.req_ready, bus.rsp_valid, cell_cs} !== '0) begin
      failures++; $display("FAIL mid_scan_after_reset state=%0d req_ready=%b exp IDLE/0", state_dbg, bus.req_ready);
    end
    reset = 1'b0;
    clear_model();
    send_req(SEARCH, 3'd0, 32'h77, lat, got, ok, acc);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (!ok || got !== e) begin failures++; $display("FAIL search_after_reset got=%h exp=%h", got, e); end
    checks++; if (lat != el) begin failures++; $display("FAIL search_after_reset_lat got=%0d exp=%0d", lat, el); end
  endtask

  task automatic test_fresh_miss();
    int lat, acc, el; logic [RW-1:0] got, e; logic ok;
    apply_reset();
    send_req(SEARCH, 3'd0, 32'h0, lat, got, ok, acc);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (!ok || got !== e) begin failures++; $display("FAIL search_zero_fresh got=%h exp=%h", got, e); end
    checks++; if (lat != 9) begin failures++; $display("FAIL search_zero_fresh_lat got=%0d exp=9", lat); end
    send_req(READ, 3'd7, 32'h0, lat, got, ok, acc);
    e = exp_q.pop_front(); el = lat_q.pop_front();
    checks++; if (!ok || got !== e) begin failures++; $display("FAIL rd7_fresh got=%h exp=%h", got, e); end
  endtask

  task automatic test_back_to_back();
    int lat, acc, el, prev_acc; logic [RW-1:0] got, e; logic ok;
    cash_op_t op, prev_op;
    logic [IW-1:0] idx; logic [DW-1:0] d;
    prev_op = SEARCH; prev_acc = 0;
    for (int i = 0; i < 24; i++) begin
      op  = cash_op_t'($urandom_range(0, 3));
      idx = IW'($urandom_range(0, NC - 1));
      d   = 32'h11 * $urandom_range(1, 3);
      send_req(op, idx, d, lat, got, ok, acc);
      e = exp_q.pop_front(); el = lat_q.pop_front();
      checks++; if (!ok || got !== e) begin failures++; $display("FAIL b2b_rsp%0d op=%0d got=%h exp=%h", i, op, got, e); end
      checks++; if (lat != el) begin failures++; $display("FAIL b2b_lat%0d op=%0d got=%0d exp=%0d", i, op, lat, el); end
      if (i > 0 && prev_op != SEARCH) begin
        checks++;
        if (acc - prev_acc != 3) begin failures++; $display("FAIL b2b_interval%0d got=%0d exp=3", i, acc - prev_acc); end
      end
      prev_op = op; prev_acc = acc;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = READ; bus.req_idx = '0; bus.req_data = '0; bus.rsp_ready = 1'b0;
    clear_model();
    test_reset();
    test_write_read();
    test_search();
    test_delete();
    test_backpressure();
    test_reset_mid_scan();
    test_fresh_miss();
    test_back_to_back();
    checks++;
    if (cs_violations != 0 || exp_q.size() != 0) begin
      failures++; $display("FAIL cs_onehot_access violations=%0d leftover=%0d exp 0/0", cs_violations, exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
